// File: rtl/ram8x72_fifo_ctrl_if.sv
// Push/pop handshake bundle for the 8x72 FIFO controller.
// master = producer/consumer side, slave = controller side.
interface ram8x72_fifo_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/ram8x72_fifo_ctrl.sv
// First-word-fall-through FIFO controller in front of an external 8x72 single-port RAM.
// Capacity is 9 words: 8 in RAM plus the registered head word.
module ram8x72_fifo_ctrl (
  input  logic                      clk,
  input  logic                      rst_n,
  ram8x72_fifo_ctrl_if.slave        bus,
  output logic [2:0]                ram_addr,
  output logic                      ram_wr_n,
  output logic [71:0]               ram_wdata,
  input  logic [71:0]               ram_rdata,
  output logic [3:0]                count,
  output logic                      full,
  output logic                      empty
);

  localparam logic [1:0] OP_IDLE   = 2'd0;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_BYPASS = 2'd2;
  localparam logic [1:0] OP_WRITE  = 2'd3;

  logic [2:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  rd_ptr_q, rd_ptr_d;
  logic [3:0]  ram_cnt_q, ram_cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [71:0] out_data_q, out_data_d;

  logic        slot_free;
  logic        ram_empty;
  logic        ram_full;
  logic        pop;
  logic [1:0]  op;

  // One RAM port: refilling the head register from RAM always wins over a write.
  always_comb begin
    pop       = out_valid_q && bus.out_ready;
    slot_free = !out_valid_q || bus.out_ready;
    ram_empty = (ram_cnt_q == 4'd0);
    ram_full  = (ram_cnt_q == 4'd8);
    op        = OP_IDLE;
    if (slot_free && !ram_empty) begin
      op = OP_READ;
    end else if (slot_free && bus.in_valid) begin
      op = OP_BYPASS;
    end else if (!slot_free && bus.in_valid && !ram_full) begin
      op = OP_WRITE;
    end
  end

  // in_ready is forced low while reset is held, even though state already reads empty.
  always_comb begin
    ram_addr      = (op == OP_WRITE) ? wr_ptr_q : rd_ptr_q;
    ram_wr_n      = !(rst_n && (op == OP_WRITE));
    ram_wdata     = bus.in_data;
    bus.in_ready  = rst_n && (op != OP_READ) && (slot_free || !ram_full);
    bus.out_valid = out_valid_q;
    bus.out_data  = out_data_q;
    count         = ram_cnt_q + {3'b000, out_valid_q};
    full          = (count == 4'd9);
    empty         = (count == 4'd0);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_cnt_d   = ram_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (pop) begin
      out_valid_d = 1'b0;
    end
    case (op)
      OP_READ: begin
        out_data_d  = ram_rdata;
        out_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + 3'd1;
        ram_cnt_d   = ram_cnt_q - 4'd1;
      end
      OP_BYPASS: begin
        out_data_d  = bus.in_data;
        out_valid_d = 1'b1;
      end
      OP_WRITE: begin
        wr_ptr_d  = wr_ptr_q + 3'd1;
        ram_cnt_d = ram_cnt_q + 4'd1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= 3'd0;
      rd_ptr_q    <= 3'd0;
      ram_cnt_q   <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 72'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_ram8x72_fifo_ctrl.sv
// Directed + randomized bench for ram8x72_fifo_ctrl with an 8x72 RAM model and a
// scoreboard queue of accepted words checked against every pop.
module tb_ram8x72_fifo_ctrl;
  logic        clk;
  logic        rst_n;
  logic [2:0]  ram_addr;
  logic        ram_wr_n;
  logic [71:0] ram_wdata;
  logic [71:0] ram_rdata;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  ram8x72_fifo_ctrl_if bus ();

  ram8x72_fifo_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .ram_addr  (ram_addr),
    .ram_wr_n  (ram_wr_n),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  logic [71:0] mem [8];
  always @(posedge clk) if (!ram_wr_n) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  logic [71:0] sb[$];
  logic [2:0] wr_m, rd_m;
  int wr_wraps, rd_wraps, nwr, rw_clash;
  logic last_acc, last_pop;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at negedge against a reference model, then advance to posedge+1.
  task automatic tick();
    int rc;
    logic sf, exp_rd, exp_wr, exp_ir;
    logic [2:0] exp_addr;
    logic [71:0] head;
    @(negedge clk);
    rc = (sb.size() == 0) ? 0 : sb.size() - 1;
    chk("count", 72'(count), 72'(sb.size()));
    chk("count_le9", 72'(count <= 4'd9), 72'(1));
    chk("full", 72'(full), 72'(sb.size() == 9));
    chk("empty", 72'(empty), 72'(sb.size() == 0));
    chk("out_valid", 72'(bus.out_valid), 72'(sb.size() != 0));
    sf       = (sb.size() == 0) || bus.out_ready;
    exp_rd   = sf && (rc != 0);
    exp_wr   = !sf && bus.in_valid && (rc != 8);
    exp_ir   = !exp_rd && (sf || (rc != 8));
    exp_addr = exp_wr ? wr_m : rd_m;
    chk("in_ready", 72'(bus.in_ready), 72'(exp_ir));
    chk("ram_wr_n", 72'(ram_wr_n), 72'(!exp_wr));
    chk("ram_addr", 72'(ram_addr), 72'(exp_addr));
    if (!ram_wr_n) nwr++;
    if (!ram_wr_n && exp_rd) rw_clash++;
    last_pop = bus.out_valid && bus.out_ready;
    last_acc = bus.in_valid && bus.in_ready;
    if (last_pop) begin
      if (sb.size() == 0) chk("pop_empty", 72'(bus.out_valid), 72'(0));
      else begin
        head = sb.pop_front();
        chk("pop_data", bus.out_data, head);
      end
    end
    if (last_acc) sb.push_back(bus.in_data);
    if (exp_wr) begin
      if (wr_m == 3'd7) wr_wraps++;
      wr_m = wr_m + 3'd1;
    end
    if (exp_rd) begin
      if (rd_m == 3'd7) rd_wraps++;
      rd_m = rd_m + 3'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k, nxt, npop;
    logic [71:0] saved;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 72'd0;
    bus.out_ready = 1'b0;
    wr_m = 3'd0; rd_m = 3'd0;
    wr_wraps = 0; rd_wraps = 0; nwr = 0; rw_clash = 0;
    last_acc = 1'b0; last_pop = 1'b0;

    // Power-on reset
    #2;
    chk("rst0_out_valid", 72'(bus.out_valid), 72'(0));
    chk("rst0_count", 72'(count), 72'(0));
    chk("rst0_empty", 72'(empty), 72'(1));
    bus.in_valid = 1'b1;
    #1;
    chk("rst0_in_ready", 72'(bus.in_ready), 72'(0));
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: reset mid-stream with five words held
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 72'(32'h500 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_count", 72'(count), 72'(5));
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    #1;
    chk("rst_out_valid", 72'(bus.out_valid), 72'(0));
    chk("rst_count", 72'(count), 72'(0));
    chk("rst_empty", 72'(empty), 72'(1));
    chk("rst_full", 72'(full), 72'(0));
    chk("rst_ram_wr_n", 72'(ram_wr_n), 72'(1));
    chk("rst_ram_addr", 72'(ram_addr), 72'(0));
    chk("rst_in_ready", 72'(bus.in_ready), 72'(0));
    chk("rst_out_data", bus.out_data, 72'(0));
    sb.delete();
    wr_m = 3'd0; rd_m = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data = 72'h0AA;
    tick();
    bus.in_valid = 1'b0;
    chk("post_rst_data", bus.out_data, 72'h0AA);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Test 2: bypass from empty
    nwr = 0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 72'h123456789ABCDEF012;
    tick();
    bus.in_valid = 1'b0;
    chk("byp_out_valid", 72'(bus.out_valid), 72'(1));
    chk("byp_out_data", bus.out_data, 72'h123456789ABCDEF012);
    tick();
    chk("byp_count", 72'(count), 72'(0));
    chk("byp_no_write", 72'(nwr), 72'(0));
    bus.out_ready = 1'b0;

    // Test 3: fill with words 1..10, word 10 must stall
    nwr = 0;
    k = 1;
    for (int c = 0; c < 20 && k <= 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 72'(k);
      tick();
      if (last_acc) k++;
    end
    chk("fill_accepted_upto", 72'(k), 72'(10));
    chk("fill_writes", 72'(nwr), 72'(8));
    chk("fill_head", bus.out_data, 72'(1));
    chk("fill_count", 72'(count), 72'(9));
    chk("fill_full", 72'(full), 72'(1));
    chk("fill_in_ready", 72'(bus.in_ready), 72'(0));

    // Test 4: drain 1..9 on consecutive cycles, then bypass word 10
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("drain_pop", 72'(last_pop), 72'(1));
    end
    chk("drain_empty", 72'(empty), 72'(1));
    nwr = 0;
    bus.in_valid = 1'b1;
    bus.in_data = 72'(10);
    tick();
    bus.in_valid = 1'b0;
    chk("w10_accepted", 72'(last_acc), 72'(1));
    chk("w10_out_data", bus.out_data, 72'(10));
    chk("w10_no_write", 72'(nwr), 72'(0));
    tick();
    bus.out_ready = 1'b0;

    // Test 5: random traffic, 40 words
    wr_wraps = 0; rd_wraps = 0; rw_clash = 0;
    nxt = 0; npop = 0;
    bus.in_valid = 1'b0;
    last_acc = 1'b0;
    for (int c = 0; c < 3000 && (nxt < 40 || sb.size() != 0); c++) begin
      if (!(bus.in_valid && !last_acc)) begin
        bus.in_valid = (nxt < 40) && ($urandom_range(0, 4) != 0);
        bus.in_data = 72'(nxt);
      end
      bus.out_ready = (nxt >= 40) || ($urandom_range(0, 3) == 0);
      tick();
      if (last_acc) nxt++;
      if (last_pop) npop++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("mix_pushed", 72'(nxt), 72'(40));
    chk("mix_popped", 72'(npop), 72'(40));
    chk("mix_left", 72'(sb.size()), 72'(0));
    chk("mix_wr_wraps_ge2", 72'(wr_wraps >= 2), 72'(1));
    chk("mix_rd_wraps_ge2", 72'(rd_wraps >= 2), 72'(1));
    chk("mix_rw_clash", 72'(rw_clash), 72'(0));

    // Test 6: stall hold with full FIFO
    k = 100;
    for (int c = 0; c < 20 && k < 109; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 72'(k);
      tick();
      if (last_acc) k++;
    end
    chk("stall_count", 72'(count), 72'(9));
    saved = bus.out_data;
    chk("stall_head", saved, 72'(100));
    bus.in_valid = 1'b1;
    bus.in_data = 72'(109);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_data", bus.out_data, saved);
      chk("stall_count9", 72'(count), 72'(9));
      chk("stall_in_ready", 72'(bus.in_ready), 72'(0));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 30 && sb.size() != 0; c++) tick();
    chk("final_empty", 72'(empty), 72'(1));
    bus.out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
